// File: rtl/ccff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ccff_loader
// Function : Serializes host bitstream words MSB-first onto the tile
//            configuration chain (ccff_head / ccff_shift_en) for a programmed
//            chain length. Optional CRC-16-CCITT check under CCFF_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_loader #(
  parameter int WORD_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic [15:0]       crc_expect,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORD_W - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_inc;
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_full;
  logic [WORD_W-1:0] r_sreg;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_head;
  logic              r_shift_en;
  logic              r_busy;
  logic              r_done;

  logic w_start_acc;
  logic w_ready;
  logic w_accept;
  logic w_shift;
  logic w_last_bit;
  logic w_word_end;
  logic w_sreg_load;
  logic w_hold_drop;
  logic w_busy_nxt;

  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_last_bit = (w_cnt_inc == r_len);
  assign w_word_end = (r_bit_idx == C_LAST_IDX);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = (chain_len == '0) ? S_DONE : S_LOAD;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (r_hold_full) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = S_CHECK;
        end else if (w_word_end && !r_hold_full) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_CHECK: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- output decode
  always_comb begin
    w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_ready     = ((r_state == S_LOAD) || (r_state == S_SHIFT)) && !r_hold_full;
    w_accept    = data_valid && w_ready;
    w_shift     = (r_state == S_SHIFT);
    // Reload straight from hold on the last bit of a word keeps the chain gapless.
    w_sreg_load = ((r_state == S_LOAD) && r_hold_full) ||
                  (w_shift && !w_last_bit && w_word_end && r_hold_full);
    w_hold_drop = (r_state == S_CHECK) || (r_state == S_DONE);
    w_busy_nxt  = r_busy;
    if (w_start_acc) begin
      w_busy_nxt = 1'b1;
    end else if (r_state == S_DONE) begin
      w_busy_nxt = 1'b0;
    end
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sreg      <= '0;
      r_bit_idx   <= '0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_len <= chain_len;
      end

      if (w_start_acc) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_accept) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end else if (w_sreg_load || w_hold_drop) begin
        r_hold_full <= 1'b0;
      end

      if (w_sreg_load) begin
        r_sreg    <= r_hold;
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_sreg    <= {r_sreg[WORD_W-2:0], 1'b0};
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end

      if (w_shift) begin
        r_head <= r_sreg[WORD_W-1];
      end
      r_shift_en <= w_shift;
      r_busy     <= w_busy_nxt;
      r_done     <= (r_state == S_DONE);
    end
  end

`ifdef CCFF_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] r_crc_exp;
  logic [15:0] w_crc_nxt;
  logic        w_crc_fb;
  logic        r_crc_err;

  // CRC-16-CCITT, MSB-first, one step per shifted chain bit.
  assign w_crc_fb  = r_crc[15] ^ r_sreg[WORD_W-1];
  assign w_crc_nxt = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      r_crc     <= 16'hFFFF;
      r_crc_exp <= '0;
      r_crc_err <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_crc     <= 16'hFFFF;
        r_crc_exp <= crc_expect;
        r_crc_err <= 1'b0;
      end else begin
        if (w_shift) begin
          r_crc <= w_crc_nxt;
        end
        if (r_state == S_CHECK) begin
          r_crc_err <= (r_crc != r_crc_exp);
        end
      end
    end
  end

  assign crc_err = r_crc_err;
`else
  logic w_unused_crc;
  assign w_unused_crc = ^crc_expect;
  assign crc_err      = 1'b0;
`endif

  assign data_ready    = w_ready;
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ccff_loader
// Function : Scoreboard bench for ccff_loader; expected chain bits are queued
//            as words are offered and popped on every enabled shift cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_loader;

  localparam int WORD_W = 8;
  localparam int LEN_W  = 16;

  logic              prog_clk   = 1'b0;
  logic              prog_reset = 1'b0;
  logic              start      = 1'b0;
  logic [LEN_W-1:0]  chain_len  = '0;
  logic [15:0]       crc_expect = '0;
  logic [WORD_W-1:0] data_in    = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              busy;
  logic              done;
  logic              crc_err;

  ccff_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .chain_len     (chain_len),
    .crc_expect    (crc_expect),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .busy          (busy),
    .done          (done),
    .crc_err       (crc_err)
  );

  always #5 prog_clk = ~prog_clk;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   q_exp[$];
  int   n_shift = 0;
  int   n_gap = 0;
  int   base_shift = 0;
  int   base_gap = 0;
  time  last_shift_t = 0;
  logic prev_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16_byte(input logic [7:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  // Chain-side monitor: every enabled cycle consumes one expected bit.
  initial begin
    forever begin
      @(negedge prog_clk);
      if (ccff_shift_en) begin
        if (!prev_en && (n_shift != base_shift)) n_gap++;
        n_shift++;
        last_shift_t = $time;
        if (q_exp.size() == 0) check("extra_bit", 32'd1, 32'd0);
        else                   check("head", {31'd0, ccff_head}, {31'd0, q_exp.pop_front()});
      end
      prev_en = ccff_shift_en;
    end
  end

  task automatic start_load(input logic [15:0] len, input logic [15:0] ce);
    base_shift = n_shift;
    base_gap   = n_gap;
    chain_len  = len;
    crc_expect = ce;
    start      = 1'b1;
    @(negedge prog_clk);
    start      = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits, input bit keep);
    int t;
    t = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (!data_ready && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check("accept_to", {31'd0, (t < 100)}, 32'd1);
    if (t < 100) begin
      for (int i = 0; i < nbits; i++) q_exp.push_back(w[7-i]);
    end
    @(negedge prog_clk);
    if (!keep) data_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_bits);
    int t;
    t = 0;
    while (!done && t < 400) begin
      @(negedge prog_clk);
      t++;
    end
    check({tag, "_done_to"}, {31'd0, (t < 400)}, 32'd1);
    check({tag, "_bits"}, n_shift - base_shift, exp_bits);
    if (exp_bits > 0) check({tag, "_lat"}, int'(($time - last_shift_t) / 10), 32'd2);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_qleft"}, q_exp.size(), 32'd0);
    @(negedge prog_clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_head"},  {31'd0, ccff_head},     32'd0);
    check({tag, "_sen"},   {31'd0, ccff_shift_en}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},          32'd0);
    check({tag, "_done"},  {31'd0, done},          32'd0);
    check({tag, "_crc"},   {31'd0, crc_err},       32'd0);
    check({tag, "_ready"}, {31'd0, data_ready},    32'd0);
  endtask

  initial begin
    logic [15:0] c;
    int t;
    repeat (3) @(negedge prog_clk);
    check_idle_outputs("rst");
    prog_reset = 1'b1;
    @(negedge prog_clk);

    // Single word
    start_load(16'd8, 16'h0);
    check("t1_busy",  {31'd0, busy},       32'd1);
    check("t1_ready", {31'd0, data_ready}, 32'd1);
    send_word(8'hA5, 8, 1'b0);
    wait_done("t1", 8);

    // Gapless multi-word
    start_load(16'd24, 16'h0);
    send_word(8'h12, 8, 1'b1);
    send_word(8'h34, 8, 1'b1);
    send_word(8'h56, 8, 1'b0);
    wait_done("t2", 24);
    check("t2_gaps", n_gap - base_gap, 32'd0);

    // Partial word, stall, ignored busy start, late word refused
    start_load(16'd11, 16'h0);
    send_word(8'hFF, 8, 1'b0);
    repeat (4) @(negedge prog_clk);
    chain_len = 16'd3;
    start     = 1'b1;
    @(negedge prog_clk);
    start     = 1'b0;
    chain_len = 16'd11;
    repeat (11) @(negedge prog_clk);
    check("t3_stall_sen",  {31'd0, ccff_shift_en}, 32'd0);
    check("t3_stall_bits", n_shift - base_shift, 32'd8);
    send_word(8'hE0, 3, 1'b0);
    wait_done("t3", 11);
    check("t3_gaps", n_gap - base_gap, 32'd1);
    data_in    = 8'h55;
    data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      check("t3_late_ready", {31'd0, data_ready}, 32'd0);
    end
    data_valid = 1'b0;
    check("t3_late_sen", {31'd0, ccff_shift_en}, 32'd0);

    // Zero length
    start_load(16'd0, 16'h0);
    wait_done("t4", 0);

    // Reset mid-load, then fresh load
    start_load(16'd16, 16'h0);
    send_word(8'hC3, 8, 1'b1);
    send_word(8'h5A, 8, 1'b0);
    t = 0;
    while ((n_shift - base_shift) < 5 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check("t5_reach5", {31'd0, (t < 100)}, 32'd1);
    #2;
    prog_reset = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    q_exp.delete();
    repeat (2) @(negedge prog_clk);
    prog_reset = 1'b1;
    @(negedge prog_clk);
    start_load(16'd16, 16'h0);
    send_word(8'hA5, 8, 1'b1);
    send_word(8'h3C, 8, 1'b0);
    wait_done("t5", 16);

`ifdef CCFF_CRC_EN
    c = crc16_byte(8'h00);
    start_load(16'd8, c);
    send_word(8'h00, 8, 1'b0);
    wait_done("t6a", 8);
    check("t6a_crc_err", {31'd0, crc_err}, 32'd0);
    start_load(16'd8, c ^ 16'h0001);
    send_word(8'h00, 8, 1'b0);
    wait_done("t6b", 8);
    check("t6b_crc_err", {31'd0, crc_err}, 32'd1);
    repeat (5) @(negedge prog_clk);
    check("t6b_crc_hold", {31'd0, crc_err}, 32'd1);
    start_load(16'd8, c);
    check("t6c_crc_clr", {31'd0, crc_err}, 32'd0);
    send_word(8'h00, 8, 1'b0);
    wait_done("t6c", 8);
    check("t6c_crc_err", {31'd0, crc_err}, 32'd0);
`else
    c = crc16_byte(8'h00) ^ 16'h0001;
    start_load(16'd8, c);
    send_word(8'h00, 8, 1'b0);
    wait_done("t6", 8);
    check("t6_crc_tied", {31'd0, crc_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t reached, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
